// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Imported by the arbiter top and its transaction tracker.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_DAT_DEF = 32'h0;

endpackage

// File: rtl/if_wb.sv
// Wishbone B4 pipelined bus bundle.
// Member names are from the master's point of view.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack, stall
  );
endinterface

// File: rtl/wb_txn_tracker.sv
// Outstanding-request counter and slave-response watchdog
// for the current bus tenure.
module wb_txn_tracker #(
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic s_ack_i,
  input  logic clear_i,
  output logic at_limit_o,
  output logic outstanding_nz_o,
  output logic synth_ack_o,
  output logic timeout_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          real_ack, dec, nz;

  assign nz               = cnt_q != '0;
  assign at_limit_o       = cnt_q == CW'(MAX_OUT);
  assign outstanding_nz_o = nz;

  // A real ack in the same cycle always beats the synthetic one.
  assign synth_ack_o = nz & ~s_ack_i & ~clear_i
                     & (wdog_q == WW'(TIMEOUT - 1));
  assign timeout_o   = synth_ack_o;
  assign real_ack    = s_ack_i & nz;
  assign dec         = real_ack | synth_ack_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (accept_i & ~dec)
      cnt_d = cnt_q + CW'(1);
    else if (dec & ~accept_i)
      cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    wdog_d = wdog_q + WW'(1);
    if (clear_i | s_ack_i | ~nz | synth_ack_o)
      wdog_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      wdog_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone B4 pipelined arbiter
// with outstanding tracking and response watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int          MAX_OUT = 4,
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] ERR_DAT = ERR_DAT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] grant,
  output logic       timeout
);

  arb_state_t  state_q;
  owner_t      last_q;
  logic [1:0]  grant_q;

  logic        own0, own1;
  logic        pick0, pick1, rel;
  logic        o_cyc, o_stb, o_we;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat;
  logic        s_stb, accept;
  logic        stall_o, ack_real, ack_o;
  logic [31:0] rd_dat;
  logic        at_limit, out_nz, synth_ack;

  assign own0 = state_q == GNT0;
  assign own1 = state_q == GNT1;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    rel   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pick0 = m0.cyc & (~m1.cyc | last_q == M1);
        pick1 = m1.cyc & ~pick0;
      end
      GNT0: begin
        pick1 = ~m0.cyc & m1.cyc;
        rel   = ~m0.cyc & ~m1.cyc;
      end
      GNT1: begin
        pick0 = ~m1.cyc & m0.cyc;
        rel   = ~m1.cyc & ~m0.cyc;
      end
      default: rel = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= M1;
      grant_q <= 2'b00;
    end else begin
      unique case (1'b1)
        pick0: begin
          state_q <= GNT0;
          last_q  <= M0;
          grant_q <= 2'b01;
        end
        pick1: begin
          state_q <= GNT1;
          last_q  <= M1;
          grant_q <= 2'b10;
        end
        rel: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign grant = grant_q;

  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_sel = '0;
    o_adr = '0;
    o_dat = '0;
    unique case (1'b1)
      own0: begin
        o_cyc = m0.cyc;
        o_stb = m0.stb;
        o_we  = m0.we;
        o_sel = m0.sel;
        o_adr = m0.adr;
        o_dat = m0.dat_o;
      end
      own1: begin
        o_cyc = m1.cyc;
        o_stb = m1.stb;
        o_we  = m1.we;
        o_sel = m1.sel;
        o_adr = m1.adr;
        o_dat = m1.dat_o;
      end
      default: ;
    endcase
  end

  // The slave never sees a strobe the owner is being stalled on.
  assign s_stb   = o_cyc & o_stb & ~at_limit;
  assign s.cyc   = o_cyc;
  assign s.stb   = s_stb;
  assign s.we    = o_we;
  assign s.sel   = o_sel;
  assign s.adr   = o_adr;
  assign s.dat_o = o_dat;

  assign accept   = s_stb & ~s.stall;
  assign stall_o  = s.stall | at_limit;
  assign ack_real = s.ack & out_nz & o_cyc;
  assign ack_o    = ack_real | synth_ack;
  assign rd_dat   = ack_real ? s.dat_i : ERR_DAT;

  assign m0.ack   = own0 & ack_o;
  assign m0.stall = ~own0 | stall_o;
  assign m0.dat_i = rd_dat;
  assign m1.ack   = own1 & ack_o;
  assign m1.stall = ~own1 | stall_o;
  assign m1.dat_i = rd_dat;

  wb_txn_tracker #(
    .MAX_OUT (MAX_OUT),
    .TIMEOUT (TIMEOUT)
  ) u_trk (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .accept_i         (accept),
    .s_ack_i          (s.ack),
    .clear_i          (~o_cyc),
    .at_limit_o       (at_limit),
    .outstanding_nz_o (out_nz),
    .synth_ack_o      (synth_ack),
    .timeout_o        (timeout)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: arbitration, pipelining,
// watchdog, abort, fairness and reset mid-burst.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       timeout;

  always #5 clk = ~clk;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb s_if ();

  wb_arbiter2 #(
    .MAX_OUT (4),
    .TIMEOUT (16),
    .ERR_DAT (32'h0)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .timeout (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Slave model: accepts every strobe, acks in order slv_dly
  // cycles after acceptance; stray forces an unsolicited ack.
  logic        slv_ack_q = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] slv_dat = 32'h0;
  bit          slv_en = 1'b0;
  int          slv_dly = 8;
  int          q_t[$];
  logic [31:0] q_d[$];

  assign s_if.ack   = slv_ack_q | stray;
  assign s_if.dat_i = slv_dat;
  assign s_if.stall = 1'b0;

  int          edge_n = 0;
  int          m0_acc[$];
  int          m0_ack_e[$];
  logic [31:0] m0_ack_d[$];
  int          m1_ack_n = 0;
  int          s_ack_n = 0;
  int          to_n = 0;

  always @(posedge clk) begin
    edge_n++;
    if (m0_if.cyc && m0_if.stb && !m0_if.stall)
      m0_acc.push_back(edge_n);
    if (m0_if.ack) begin
      m0_ack_e.push_back(edge_n);
      m0_ack_d.push_back(m0_if.dat_i);
    end
    if (m1_if.ack) m1_ack_n++;
    if (s_if.ack) s_ack_n++;
    if (timeout) to_n++;
    if (slv_ack_q && q_t.size() > 0) begin
      q_t.delete(0);
      q_d.delete(0);
    end
    if (s_if.cyc && s_if.stb && !s_if.stall) begin
      q_t.push_back(edge_n);
      q_d.push_back(s_if.adr);
    end
    #2;
    slv_ack_q = slv_en && q_t.size() > 0
              && (edge_n >= q_t[0] + slv_dly - 1);
    slv_dat = slv_ack_q ? (32'hA000_0000 | q_d[0]) : 32'h0;
  end

  bit         mon_en = 1'b0;
  logic [1:0] g_prev = 2'b00;
  logic [1:0] g_last = 2'b00;
  int         viol = 0;
  int         n_g0 = 0;
  int         n_g1 = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != g_prev && grant != 2'b00) begin
        if (grant == g_last) viol++;
        if (grant == 2'b01) n_g0++;
        else n_g1++;
        g_last = grant;
      end
      g_prev = grant;
    end
  end

  task automatic drv(input int m, input logic cyc,
                     input logic stb, input logic [31:0] adr);
    if (m == 0) begin
      m0_if.cyc = cyc;
      m0_if.stb = stb;
      m0_if.adr = adr;
    end else begin
      m1_if.cyc = cyc;
      m1_if.stb = stb;
      m1_if.adr = adr;
    end
  endtask

  function automatic logic stl(input int m);
    return (m == 0) ? m0_if.stall : m1_if.stall;
  endfunction

  function automatic logic ackm(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  task automatic wait_grant(input logic [1:0] g);
    for (int k = 0; k < 50 && grant != g; k++) begin
      @(negedge clk);
      #1;
    end
    check("grant_wait", grant, g);
  endtask

  task automatic issue(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drv(m, 1'b1, 1'b1, i);
      #1;
      for (int k = 0; k < 40 && stl(m); k++) begin
        @(negedge clk);
        #1;
      end
      if (stl(m)) check("issue_stall", stl(m), 1'b0);
    end
    @(negedge clk);
    drv(m, 1'b1, 1'b0, 0);
  endtask

  task automatic tenure(input int m);
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    drv(m, 1'b1, 1'b0, 0);
    #1;
    for (int k = 0; k < 60 && grant != g; k++) begin
      @(negedge clk);
      #1;
    end
    if (grant != g) check("ten_grant", grant, g);
    drv(m, 1'b1, 1'b1, m);
    #1;
    @(negedge clk);
    drv(m, 1'b1, 1'b0, 0);
    #1;
    for (int k = 0; k < 20 && !ackm(m); k++) begin
      @(negedge clk);
      #1;
    end
    if (!ackm(m)) check("ten_ack", ackm(m), 1'b1);
    @(negedge clk);
    drv(m, 1'b0, 1'b0, 0);
  endtask

  task automatic clr_slave();
    q_t.delete();
    q_d.delete();
    m0_acc.delete();
    m0_ack_e.delete();
    m0_ack_d.delete();
    m1_ack_n = 0;
    s_ack_n = 0;
    to_n = 0;
  endtask

  initial begin
    m0_if.we = 1'b0;
    m0_if.sel = 4'hf;
    m0_if.dat_o = 32'h0;
    m1_if.we = 1'b0;
    m1_if.sel = 4'hf;
    m1_if.dat_o = 32'h0;
    drv(0, 1'b0, 1'b0, 0);
    drv(1, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_scyc", s_if.cyc, 1'b0);
    check("rst_m0_stall", m0_if.stall, 1'b1);
    check("rst_m1_stall", m1_if.stall, 1'b1);
    check("rst_m0_ack", m0_if.ack, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous request, then handover without idle
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 0);
    drv(1, 1'b1, 1'b0, 0);
    #1;
    check("arb_latency", grant, 2'b00);
    @(negedge clk);
    #1;
    check("arb_first", grant, 2'b01);
    repeat (3) @(negedge clk);
    drv(0, 1'b0, 1'b0, 0);
    #1;
    check("arb_drop_hold", grant, 2'b01);
    check("arb_drop_scyc", s_if.cyc, 1'b0);
    @(negedge clk);
    #1;
    check("arb_handover", grant, 2'b10);
    drv(1, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    check("arb_idle", grant, 2'b00);

    // Pipelining with outstanding limit
    clr_slave();
    slv_en = 1'b1;
    slv_dly = 8;
    drv(0, 1'b1, 1'b0, 0);
    wait_grant(2'b01);
    issue(0, 6);
    for (int k = 0; k < 60 && m0_ack_e.size() < 6; k++)
      @(negedge clk);
    check("pipe_acks", m0_ack_e.size(), 6);
    check("pipe_accepts", m0_acc.size(), 6);
    check("pipe_4_before_ack",
          m0_acc[3] < m0_ack_e[0], 1'b1);
    check("pipe_5th_after_ack", m0_acc[4], m0_ack_e[0] + 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("pipe_dat%0d", i), m0_ack_d[i],
            32'hA000_0000 | i);

    // Watchdog synthetic ack and stray slave ack
    @(negedge clk);
    clr_slave();
    slv_en = 1'b0;
    issue(0, 1);
    for (int k = 0; k < 40 && m0_ack_e.size() < 1; k++)
      @(negedge clk);
    check("wd_ack_cnt", m0_ack_e.size(), 1);
    check("wd_delay", m0_ack_e[0] - m0_acc[0], 16);
    check("wd_dat", m0_ack_d[0], 32'h0);
    check("wd_pulse", to_n, 1);
    for (int k = 0; k < 40 && edge_n < m0_acc[0] + 19; k++)
      @(negedge clk);
    stray = 1'b1;
    #1;
    check("stray_ack", m0_if.ack, 1'b0);
    check("stray_timeout", timeout, 1'b0);
    @(negedge clk);
    stray = 1'b0;
    #1;
    check("stray_not_fwd", m0_ack_e.size(), 1);
    check("stray_seen", s_ack_n, 1);
    check("wd_pulse_once", to_n, 1);

    // Abort with three outstanding
    clr_slave();
    slv_en = 1'b1;
    slv_dly = 8;
    drv(0, 1'b0, 1'b0, 0);
    drv(1, 1'b1, 1'b0, 0);
    wait_grant(2'b10);
    issue(1, 3);
    @(negedge clk);
    drv(1, 1'b0, 1'b0, 0);
    #1;
    check("abort_scyc", s_if.cyc, 1'b0);
    @(negedge clk);
    #1;
    check("abort_cnt", dut.u_trk.cnt_q, 0);
    check("abort_grant", grant, 2'b00);
    repeat (15) @(negedge clk);
    check("abort_slave_acks", s_ack_n, 3);
    check("abort_m1_acks", m1_ack_n, 0);
    check("abort_m0_acks", m0_ack_e.size(), 0);

    // Fairness: alternating one-transaction tenures
    clr_slave();
    slv_en = 1'b1;
    slv_dly = 1;
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 50; i++) tenure(0);
      end
      begin
        for (int j = 0; j < 50; j++) tenure(1);
      end
    join
    @(negedge clk);
    mon_en = 1'b0;
    check("fair_viol", viol, 0);
    check("fair_m0", n_g0, 50);
    check("fair_m1", n_g1, 50);

    // Reset mid-burst
    clr_slave();
    slv_en = 1'b0;
    drv(0, 1'b1, 1'b0, 0);
    wait_grant(2'b01);
    issue(0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_scyc", s_if.cyc, 1'b0);
    check("mid_rst_m0_stall", m0_if.stall, 1'b1);
    check("mid_rst_m1_stall", m1_if.stall, 1'b1);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
